// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
// Stages raise stall requests and report committed exceptions; the controller
// answers with per-register hold enables, a one-cycle flush and the redirect PC.
// These are level signals sampled every rising clock edge: a request counts in a
// cycle exactly when it is high at that edge, and there is no valid/ready pairing.
interface pipe_ctrl_if;
  logic        if_stallreq;
  logic        id_stallreq;
  logic        ex_stallreq;
  logic        mem_stallreq;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;

  // Pipeline side: drives requests, receives controls.
  modport master (
    output if_stallreq, id_stallreq, ex_stallreq, mem_stallreq, exc_valid, exc_pc,
    input  stall, flush, new_pc, stall_timeout
  );

  // Controller side.
  modport slave (
    input  if_stallreq, id_stallreq, ex_stallreq, mem_stallreq, exc_valid, exc_pc,
    output stall, flush, new_pc, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// The highest requesting stage decides how far back the pipe holds. An exception
// waits for both buses to go idle, then produces a single flush cycle carrying
// the first exception's redirect PC. A sticky watchdog flags a PC that stays
// held for STALL_TIMEOUT consecutive cycles.
module pipe_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 255,  // 1 .. 2**CNT_W-1
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  pipe_ctrl_if.slave bus,
  output logic [1:0] o_dbg_state   // current FSM state for observation
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_FLUSH_WAIT = 2'd1,
    S_FLUSH      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(STALL_TIMEOUT);

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  logic [4:0]       w_stall;
  logic             w_flush;
  logic             w_buses_idle;
  logic [CNT_W-1:0] w_cnt_next;

  // Flush may only proceed once neither bus has a transaction outstanding.
  assign w_buses_idle = !bus.if_stallreq && !bus.mem_stallreq;

  // Stall enables: priority decode in RUN, full hold while waiting, none in FLUSH.
  // Held low during reset so no stage freezes while the controller is cleared.
  always_comb begin
    w_stall = 5'b00000;
    if (rst) begin
      case (r_state)
        S_RUN: begin
          if (bus.mem_stallreq)     w_stall = 5'b11111;
          else if (bus.ex_stallreq) w_stall = 5'b01111;
          else if (bus.id_stallreq) w_stall = 5'b00111;
          else if (bus.if_stallreq) w_stall = 5'b00011;
          else                      w_stall = 5'b00000;
        end
        S_FLUSH_WAIT: w_stall = 5'b11111;
        default:      w_stall = 5'b00000;
      endcase
    end
  end

  assign w_flush = rst && (r_state == S_FLUSH);

  // Watchdog next value: count held-PC cycles, saturate, clear when the PC moves.
  always_comb begin
    w_cnt_next = r_cnt;
    if ((r_state == S_FLUSH) || !w_stall[0]) begin
      w_cnt_next = '0;
    end else if (r_cnt != TIMEOUT_VAL) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Exception sequencing FSM; the first exception's PC is kept until its flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_pc    <= 32'h0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.exc_valid) begin
            r_pc    <= bus.exc_pc;
            r_state <= w_buses_idle ? S_FLUSH : S_FLUSH_WAIT;
          end
        end
        S_FLUSH_WAIT: begin
          if (w_buses_idle) r_state <= S_FLUSH;
        end
        S_FLUSH: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Watchdog counter and its sticky flag; only reset clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_cnt_next == TIMEOUT_VAL) r_timeout <= 1'b1;
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.new_pc        = w_flush ? r_pc : 32'h0;
  assign bus.stall_timeout = r_timeout;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: each scenario task drives one step per clock, pushes the
// expected {state, stall, flush, new_pc, stall_timeout} to exp_q, and compares
// against the DUT at the falling edge.
module tb_pipe_ctrl;
  localparam int unsigned TO = 4;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_FW  = 2'd1;
  localparam logic [1:0] ST_FL  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [40:0] exp_q[$];

  pipe_ctrl_if pci();

  pipe_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(pci),
    .o_dbg_state(dbg_state)
  );

  // Clock / time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // Expected-value packing: {state, stall, flush, new_pc, stall_timeout}
  function automatic logic [40:0] mk(input logic [1:0] st, input logic [4:0] stl,
                                     input logic fl, input logic [31:0] pc, input logic to);
    return {st, stl, fl, pc, to};
  endfunction

  // Stimulus packing: {exc_valid, if, id, ex, mem, exc_pc}
  function automatic logic [36:0] sv(input logic exc, input logic ifr, input logic idr,
                                     input logic exr, input logic memr, input logic [31:0] pc);
    return {exc, ifr, idr, exr, memr, pc};
  endfunction

  function automatic string fmt(input logic [40:0] v);
    return $sformatf("st=%0d stall=%b flush=%b new_pc=%h timeout=%b",
                     v[40:39], v[38:34], v[33], v[32:1], v[0]);
  endfunction

  function automatic logic [40:0] observe();
    return {dbg_state, pci.stall, pci.flush, pci.new_pc, pci.stall_timeout};
  endfunction

  // Driver tasks
  task automatic drive(input logic [36:0] s);
    {pci.exc_valid, pci.if_stallreq, pci.id_stallreq, pci.ex_stallreq,
     pci.mem_stallreq, pci.exc_pc} = s;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b0;
    drive('0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Reset state with every input asserted
  task automatic test_reset();
    logic [40:0] got, want;
    rst = 1'b0;
    drive(sv(1, 1, 1, 1, 1, 32'hFFFF_FFFF));
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(ST_RUN, 5'b00000, 0, 32'h0, 0));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL reset[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    @(posedge clk); #1;
    drive('0);
    rst = 1'b1;
  endtask

  // Priority of stall requests
  task automatic test_priority();
    logic [36:0] stim [4];
    logic [40:0] expv [4];
    logic [40:0] got, want;
    reset_dut();
    stim[0] = sv(0, 0, 1, 1, 0, 0); expv[0] = mk(ST_RUN, 5'b01111, 0, 0, 0);
    stim[1] = sv(0, 0, 1, 0, 0, 0); expv[1] = mk(ST_RUN, 5'b00111, 0, 0, 0);
    stim[2] = sv(0, 1, 0, 0, 1, 0); expv[2] = mk(ST_RUN, 5'b11111, 0, 0, 0);
    stim[3] = sv(0, 0, 0, 0, 0, 0); expv[3] = mk(ST_RUN, 5'b00000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL priority[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Exception with both buses idle: flush on the next cycle
  task automatic test_clean_exc();
    logic [36:0] stim [3];
    logic [40:0] expv [3];
    logic [40:0] got, want;
    reset_dut();
    stim[0] = sv(1, 0, 0, 0, 0, 32'hBFC0_0380); expv[0] = mk(ST_RUN, 5'b00000, 0, 32'h0, 0);
    stim[1] = sv(0, 0, 0, 0, 0, 32'h0);         expv[1] = mk(ST_FL,  5'b00000, 1, 32'hBFC0_0380, 0);
    stim[2] = sv(0, 0, 0, 0, 0, 32'h0);         expv[2] = mk(ST_RUN, 5'b00000, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL clean_exc[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Exception while the data bus is busy; second exception ignored; id/ex do not delay.
  // Four consecutive held-PC cycles also trip the watchdog (timeout of 4).
  task automatic test_busy_exc();
    logic [36:0] stim [6];
    logic [40:0] expv [6];
    logic [40:0] got, want;
    reset_dut();
    stim[0] = sv(1, 0, 0, 0, 1, 32'h8000_0180); expv[0] = mk(ST_RUN, 5'b11111, 0, 32'h0, 0);
    stim[1] = sv(1, 0, 0, 0, 1, 32'h1234_5678); expv[1] = mk(ST_FW,  5'b11111, 0, 32'h0, 0);
    stim[2] = sv(0, 0, 0, 0, 1, 32'h0);         expv[2] = mk(ST_FW,  5'b11111, 0, 32'h0, 0);
    stim[3] = sv(0, 0, 1, 1, 0, 32'h0);         expv[3] = mk(ST_FW,  5'b11111, 0, 32'h0, 0);
    stim[4] = sv(0, 0, 0, 0, 1, 32'h0);         expv[4] = mk(ST_FL,  5'b00000, 1, 32'h8000_0180, 1);
    stim[5] = sv(0, 0, 0, 0, 0, 32'h0);         expv[5] = mk(ST_RUN, 5'b00000, 0, 32'h0, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL busy_exc[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Exception and stall request arriving in the FLUSH cycle are ignored
  task automatic test_exc_in_flush();
    logic [36:0] stim [4];
    logic [40:0] expv [4];
    logic [40:0] got, want;
    reset_dut();
    stim[0] = sv(1, 0, 0, 0, 0, 32'hA000_0000); expv[0] = mk(ST_RUN, 5'b00000, 0, 32'h0, 0);
    stim[1] = sv(1, 1, 0, 0, 0, 32'hDEAD_BEEF); expv[1] = mk(ST_FL,  5'b00000, 1, 32'hA000_0000, 0);
    stim[2] = sv(0, 0, 0, 0, 0, 32'h0);         expv[2] = mk(ST_RUN, 5'b00000, 0, 32'h0, 0);
    stim[3] = sv(0, 0, 0, 0, 0, 32'h0);         expv[3] = mk(ST_RUN, 5'b00000, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL exc_in_flush[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Watchdog trips after the 4th held cycle and stays set
  task automatic test_watchdog();
    logic [36:0] stim [7];
    logic [40:0] expv [7];
    logic [40:0] got, want;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      stim[i] = sv(0, 1, 0, 0, 0, 0);
      expv[i] = mk(ST_RUN, 5'b00011, 0, 0, (i >= 4) ? 1'b1 : 1'b0);
    end
    stim[5] = sv(0, 0, 0, 0, 0, 0); expv[5] = mk(ST_RUN, 5'b00000, 0, 0, 1);
    stim[6] = sv(0, 0, 0, 0, 0, 0); expv[6] = mk(ST_RUN, 5'b00000, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL watchdog[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Three held cycles then a release: watchdog stays clear and restarts
  task automatic test_watchdog_short();
    logic [36:0] stim [5];
    logic [40:0] expv [5];
    logic [40:0] got, want;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      stim[i] = sv(0, 1, 0, 0, 0, 0); expv[i] = mk(ST_RUN, 5'b00011, 0, 0, 0);
    end
    stim[3] = sv(0, 0, 0, 0, 0, 0); expv[3] = mk(ST_RUN, 5'b00000, 0, 0, 0);
    stim[4] = sv(0, 1, 0, 0, 0, 0); expv[4] = mk(ST_RUN, 5'b00011, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL watchdog_short[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Asynchronous reset in the middle of FLUSH_WAIT, then normal operation
  task automatic test_reset_mid();
    logic [36:0] stim [5];
    logic [40:0] expv [5];
    logic [36:0] post_stim [3];
    logic [40:0] post_expv [3];
    logic [40:0] got, want;
    reset_dut();
    stim[0] = sv(1, 0, 0, 0, 1, 32'h1111_0000); expv[0] = mk(ST_RUN, 5'b11111, 0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      stim[i] = sv(0, 0, 0, 0, 1, 0);
      expv[i] = mk(ST_FW, 5'b11111, 0, 0, (i == 4) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(stim[i]);
      exp_q.push_back(expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL reset_mid_pre[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
    // Between edges, with mem_stallreq still high
    #2;
    rst = 1'b0;
    exp_q.push_back(mk(ST_RUN, 5'b00000, 0, 32'h0, 0));
    #1;
    got = observe(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL reset_mid_async: got %s, expected %s", fmt(got), fmt(want));
    end
    @(posedge clk); #1;
    drive('0);
    rst = 1'b1;
    post_stim[0] = sv(0, 0, 0, 0, 0, 0); post_expv[0] = mk(ST_RUN, 5'b00000, 0, 0, 0);
    post_stim[1] = sv(0, 0, 1, 0, 0, 0); post_expv[1] = mk(ST_RUN, 5'b00111, 0, 0, 0);
    post_stim[2] = sv(0, 0, 0, 0, 0, 0); post_expv[2] = mk(ST_RUN, 5'b00000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(post_stim[i]);
      exp_q.push_back(post_expv[i]);
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL reset_mid_post[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
    end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_priority();
    test_clean_exc();
    test_busy_exc();
    test_exc_in_flush();
    test_watchdog();
    test_watchdog_short();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush controller for the five-stage pipeline. It collects stall requests from the IF, ID, EX and MEM stages and drives per-register stall enables for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences exception flushes: it holds the pipe until outstanding bus transactions drain, then issues a one-cycle flush with the redirect PC. A watchdog flags stalls that never resolve.

Parameters:
STALL_TIMEOUT, 255, consecutive fully-stalled-PC cycles before stall_timeout sets (1..2^CNT_W-1)
CNT_W, 8, width of watchdog counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_stallreq  in  1  instruction bus busy / fetch not returned
id_stallreq  in  1  load-use hazard in ID
ex_stallreq  in  1  multi-cycle EX op (mul/div) not finished
mem_stallreq  in  1  data bus busy
exc_valid  in  1  exception/eret committed in MEM this cycle
exc_pc  in  32  redirect target accompanying exc_valid
stall  out  5  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB hold
flush  out  1  clear IF/ID, ID/EX, EX/MEM to bubbles
new_pc  out  32  redirect PC, valid while flush=1
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state=RUN, latched PC=0, counter=0, stall_timeout=0; outputs stall=0, flush=0, new_pc=0 while rst=0.
- States: RUN, FLUSH_WAIT, FLUSH. State, latched PC, counter and stall_timeout are registered. stall, flush and new_pc are combinational decodes of state and inputs.
- RUN, stall encoding: the highest requesting stage wins. mem_stallreq gives 5'b11111; else ex_stallreq gives 5'b01111; else id_stallreq gives 5'b00111; else if_stallreq gives 5'b00011; else 5'b00000. Downstream registers of the winning stage run on and insert bubbles.
- RUN with exc_valid=1:
  - Latch exc_pc.
  - If if_stallreq=0 and mem_stallreq=0, next=FLUSH. Otherwise next=FLUSH_WAIT.
  - The stall encoding above still applies this cycle.
- FLUSH_WAIT:
  - stall=5'b11111 regardless of requests.
  - Further exc_valid is ignored; the first exception wins and the latched PC is not overwritten.
  - When if_stallreq=0 and mem_stallreq=0 in the same cycle, next=FLUSH.
  - id_stallreq and ex_stallreq do not delay the flush.
- FLUSH (exactly one cycle): flush=1, new_pc=latched PC, stall=5'b00000. exc_valid and all stallreqs are ignored. Next=RUN.
- flush=0 and new_pc=0 in all states other than FLUSH.
- Latency: an exception with buses idle in cycle N gives flush=1 in cycle N+1.
- Watchdog counter:
  - Increments each cycle stall[0]=1; saturates at STALL_TIMEOUT.
  - Clears to 0 when stall[0]=0 or state=FLUSH.
  - stall_timeout sets on the cycle the counter reaches STALL_TIMEOUT. It stays set until rst=0; flush does not clear it.
- Boundaries:
  - Simultaneous exc_valid and mem_stallreq in RUN goes to FLUSH_WAIT, not FLUSH.
  - Buses going idle in the same cycle as exc_valid arrives (both low) goes to FLUSH directly.
  - Reset asserted mid-FLUSH_WAIT or FLUSH aborts to RUN with no flush pulse after release.
- Arithmetic: the counter compare is unsigned CNT_W-bit. STALL_TIMEOUT must fit CNT_W.

Test Plan:
- Priority: id_stallreq=1 and ex_stallreq=1 together -> stall=5'b01111; drop ex -> 5'b00111; drop both -> 5'b00000, flush=0 throughout.
- Clean exception: buses idle, exc_valid=1 with exc_pc=0xBFC00380 in cycle N -> cycle N+1 flush=1, new_pc=0xBFC00380, stall=0; cycle N+2 flush=0, state RUN.
- Busy exception: mem_stallreq=1 for 3 cycles, exc_valid=1 with exc_pc=0x80000180 in the first of them -> stall=5'b11111 for 3 cycles; flush=1 with new_pc=0x80000180 exactly one cycle after mem_stallreq falls. A second exc_valid with exc_pc=0x12345678 during the wait is ignored.
- Watchdog: STALL_TIMEOUT=4, if_stallreq held high -> stall_timeout=1 after the 4th stalled cycle and remains 1 after if_stallreq drops; a second run with the request dropped after 3 cycles -> stall_timeout stays 0.
- Reset mid-sequence: enter FLUSH_WAIT, pulse rst=0 asynchronously between edges -> stall, flush, new_pc and stall_timeout all 0 immediately; after release, no flush pulse and stall follows requests.
- Exception ignored during FLUSH: exc_valid=1 in the FLUSH cycle -> only one flush cycle, next state RUN.
